// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller: FSM state
// encoding, default multiplier/divider latencies and the latency-counter width.
package pipe_ctrl_pkg;

   // Default EX-side latencies of the multi-cycle units.
   localparam int unsigned MUL_CYCLES_DEF = 4;
   localparam int unsigned DIV_CYCLES_DEF = 32;

   // Latencies may reach 63, so the down-counter is 6 bits wide.
   localparam int CNT_W = 6;

   // Two-bit FSM state encoding.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } md_state_e;

   // Counter value loaded in the start cycle. The start cycle is the first
   // stalled cycle, so the counter holds latency-1.
   function automatic logic [CNT_W-1:0] latency_load(input logic        is_div,
                                                     input int unsigned mul_c,
                                                     input int unsigned div_c);
      int unsigned lat;
      lat = is_div ? div_c : mul_c;
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the instruction in ID reads a register that the
// load currently in EX has not yet written back. Purely combinational.
module hazard_detect (
   input  logic [4:0] rs_addr_i,
   input  logic [4:0] rt_addr_i,
   input  logic       uses_rs_i,
   input  logic       uses_rt_i,
   input  logic       is_lw_ex_i,
   input  logic       write_ex_i,
   input  logic [4:0] w_addr_ex_i,
   output logic       load_use_o
);

   logic rs_hit;
   logic rt_hit;

   // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
   always_comb begin
      rs_hit     = uses_rs_i & (rs_addr_i == w_addr_ex_i);
      rt_hit     = uses_rt_i & (rt_addr_i == w_addr_ex_i);
      load_use_o = is_lw_ex_i & write_ex_i & (w_addr_ex_i != 5'd0) & (rs_hit | rt_hit);
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller. Combines the load-use interlock with the
// sequencing of the multi-cycle multiplier/divider, suppresses ID-stage
// flushes while stalled, and counts stalled cycles with saturation.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs_addr_id,
   input  logic [4:0]  rt_addr_id,
   input  logic        uses_rs_id,
   input  logic        uses_rt_id,
   input  logic        is_mul_id,
   input  logic        is_div_id,
   input  logic        branch_taken_id,
   input  logic        is_lw_ex,
   input  logic        write_ex,
   input  logic [4:0]  w_addr_ex,
   output logic        stall_pc,
   output logic        stall_if_id,
   output logic        bubble_id_ex,
   output logic        flush_if_id,
   output logic        md_start,
   output logic        md_is_div,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cycles
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [31:0]      stall_cnt_q, stall_cnt_d;

   logic             load_use;
   logic             md_req;
   logic             start_c;
   logic             busy_c;
   logic             stall_c;

   hazard_detect u_hazard_detect (
      .rs_addr_i   (rs_addr_id),
      .rt_addr_i   (rt_addr_id),
      .uses_rs_i   (uses_rs_id),
      .uses_rt_i   (uses_rt_id),
      .is_lw_ex_i  (is_lw_ex),
      .write_ex_i  (write_ex),
      .w_addr_ex_i (w_addr_ex),
      .load_use_o  (load_use)
   );

   assign md_req = is_mul_id | is_div_id;

   // Next-state logic of the multiply/divide sequencer and the stall request.
   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      start_c  = 1'b0;
      busy_c   = 1'b0;
      stall_c  = 1'b0;
      case (state_q)
         IDLE: begin
            // A load-use hazard wins: the operation starts once the load
            // has moved on and the bubble sits in EX.
            if (md_req && !load_use) begin
               start_c  = 1'b1;
               busy_c   = 1'b1;
               state_d  = BUSY;
               cnt_d    = latency_load(is_div_id, MUL_CYCLES, DIV_CYCLES);
               is_div_d = is_div_id;
            end
            stall_c = load_use | start_c;
         end
         BUSY: begin
            // EX holds a bubble here, so the load-use term is irrelevant.
            stall_c = 1'b1;
            busy_c  = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // The waiting instruction advances; new requests are ignored
            // for this one cycle.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Saturating count of stalled cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // State, latency counter, operation type and stall counter registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_div_q    <= is_div_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Output decode. The combinational terms are qualified with reset so
   // that a live hazard on the inputs cannot raise a stall while in reset.
   always_comb begin
      stall_pc     = rst & stall_c;
      stall_if_id  = rst & stall_c;
      bubble_id_ex = rst & stall_c;
      flush_if_id  = rst & branch_taken_id & ~stall_c;
      md_start     = rst & start_c;
      md_busy      = rst & busy_c;
      md_done      = (state_q == DONE);
      // Valid from the start cycle onward and held until the next start.
      md_is_div    = rst & (start_c ? is_div_id : is_div_q);
      stall_cycles = stall_cnt_q;
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl with default latencies (MUL=4, DIV=32).
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_pipe_stall_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  rs_addr_id, rt_addr_id, w_addr_ex;
   logic        uses_rs_id, uses_rt_id, is_mul_id, is_div_id;
   logic        branch_taken_id, is_lw_ex, write_ex;
   logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id;
   logic        md_start, md_is_div, md_busy, md_done;
   logic [31:0] stall_cycles;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_cnt;

   pipe_stall_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .rs_addr_id      (rs_addr_id),
      .rt_addr_id      (rt_addr_id),
      .uses_rs_id      (uses_rs_id),
      .uses_rt_id      (uses_rt_id),
      .is_mul_id       (is_mul_id),
      .is_div_id       (is_div_id),
      .branch_taken_id (branch_taken_id),
      .is_lw_ex        (is_lw_ex),
      .write_ex        (write_ex),
      .w_addr_ex       (w_addr_ex),
      .stall_pc        (stall_pc),
      .stall_if_id     (stall_if_id),
      .bubble_id_ex    (bubble_id_ex),
      .flush_if_id     (flush_if_id),
      .md_start        (md_start),
      .md_is_div       (md_is_div),
      .md_busy         (md_busy),
      .md_done         (md_done),
      .stall_cycles    (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       lw;
      logic       wr;
      logic [4:0] wa;
      logic       br;
      logic       exp_stall;
      logic       exp_flush;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic lw,
                               input logic wr, input logic [4:0] wa, input logic br,
                               input logic es, input logic ef);
      vec_t v;
      v.name = nm; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
      v.lw = lw; v.wr = wr; v.wa = wa; v.br = br;
      v.exp_stall = es; v.exp_flush = ef;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      check(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic clear_inputs();
      rs_addr_id = '0; rt_addr_id = '0; w_addr_ex = '0;
      uses_rs_id = 0; uses_rt_id = 0; is_mul_id = 0; is_div_id = 0;
      branch_taken_id = 0; is_lw_ex = 0; write_ex = 0;
   endtask

   task automatic set_lu(input logic on);
      is_lw_ex = on; write_ex = on; w_addr_ex = on ? 5'd8 : 5'd0;
      uses_rs_id = on; rs_addr_id = on ? 5'd8 : 5'd0;
   endtask

   // Called just after a falling edge with inputs already applied: samples all
   // outputs, advances the stall-count model, then waits for the next falling edge.
   task automatic cyc_check(input string tag, input logic e_stall, input logic e_busy,
                            input logic e_start, input logic e_done, input logic e_flush,
                            input logic e_div);
      #1;
      chk1({tag, ".stall_pc"},     stall_pc,     e_stall);
      chk1({tag, ".stall_if_id"},  stall_if_id,  e_stall);
      chk1({tag, ".bubble_id_ex"}, bubble_id_ex, e_stall);
      chk1({tag, ".md_busy"},      md_busy,      e_busy);
      chk1({tag, ".md_start"},     md_start,     e_start);
      chk1({tag, ".md_done"},      md_done,      e_done);
      chk1({tag, ".flush_if_id"},  flush_if_id,  e_flush);
      chk1({tag, ".md_is_div"},    md_is_div,    e_div);
      check({tag, ".stall_cycles"}, stall_cycles, exp_cnt);
      if (e_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, ".stall_pc"},     stall_pc,     1'b0);
      chk1({tag, ".stall_if_id"},  stall_if_id,  1'b0);
      chk1({tag, ".bubble_id_ex"}, bubble_id_ex, 1'b0);
      chk1({tag, ".flush_if_id"},  flush_if_id,  1'b0);
      chk1({tag, ".md_start"},     md_start,     1'b0);
      chk1({tag, ".md_is_div"},    md_is_div,    1'b0);
      chk1({tag, ".md_busy"},      md_busy,      1'b0);
      chk1({tag, ".md_done"},      md_done,      1'b0);
      check({tag, ".stall_cycles"}, stall_cycles, 32'd0);
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_stall;
      bit  done_seen;
      bit  div_at_done;
      bit  stall_at_done;

      exp_cnt = '0;
      clear_inputs();

      // ---------------- reset state with hazard and requests on the inputs
      rst = 1'b0;
      set_lu(1'b1);
      is_mul_id = 1; branch_taken_id = 1;
      #3;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset_held");
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);

      // ---------------- table-driven combinational vectors in IDLE
      //           name          rs     rt     urs urt lw wr wa     br stall flush
      vecs.push_back(mk("lu_rs",      5'd8,  5'd0,  1, 0, 1, 1, 5'd8,  0, 1, 0));
      vecs.push_back(mk("lu_wa0",     5'd8,  5'd0,  1, 0, 1, 1, 5'd0,  0, 0, 0));
      vecs.push_back(mk("lu_r0",      5'd0,  5'd0,  1, 1, 1, 1, 5'd0,  0, 0, 0));
      vecs.push_back(mk("lu_rt",      5'd3,  5'd9,  1, 1, 1, 1, 5'd9,  0, 1, 0));
      vecs.push_back(mk("rt_unused",  5'd3,  5'd9,  1, 0, 1, 1, 5'd9,  0, 0, 0));
      vecs.push_back(mk("rs_unused",  5'd8,  5'd0,  0, 0, 1, 1, 5'd8,  0, 0, 0));
      vecs.push_back(mk("not_load",   5'd8,  5'd0,  1, 0, 0, 1, 5'd8,  0, 0, 0));
      vecs.push_back(mk("no_write",   5'd8,  5'd0,  1, 0, 1, 0, 5'd8,  0, 0, 0));
      vecs.push_back(mk("addr_diff",  5'd7,  5'd6,  1, 1, 1, 1, 5'd8,  0, 0, 0));
      vecs.push_back(mk("br_free",    5'd1,  5'd2,  1, 1, 0, 0, 5'd1,  1, 0, 1));
      vecs.push_back(mk("br_lu",      5'd31, 5'd0,  1, 0, 1, 1, 5'd31, 1, 1, 0));
      vecs.push_back(mk("idle",       5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 0, 0));
      foreach (vecs[i]) begin
         rs_addr_id = vecs[i].rs; rt_addr_id = vecs[i].rt;
         uses_rs_id = vecs[i].urs; uses_rt_id = vecs[i].urt;
         is_lw_ex = vecs[i].lw; write_ex = vecs[i].wr; w_addr_ex = vecs[i].wa;
         branch_taken_id = vecs[i].br;
         cyc_check(vecs[i].name, vecs[i].exp_stall, 1'b0, 1'b0, 1'b0, vecs[i].exp_flush, 1'b0);
      end
      clear_inputs();

      // ---------------- MUL held in IDLE, branch pending throughout:
      // start at 0, stalls 0-3, done at 4, restart at 5 (back-to-back), done at 9
      for (int c = 0; c < 10; c++) begin
         logic es;
         is_mul_id = (c <= 5);
         branch_taken_id = 1'b1;
         es = (c <= 3) || (c >= 5 && c <= 8);
         cyc_check($sformatf("mul_c%0d", c), es, es, (c == 0 || c == 5),
                   (c == 4 || c == 9), !es, 1'b0);
      end
      clear_inputs();
      cyc_check("mul_idle", 0, 0, 0, 0, 0, 0);

      // ---------------- load-use defers a MUL start by one cycle
      set_lu(1'b1); is_mul_id = 1;
      cyc_check("lumul_c0", 1, 0, 0, 0, 0, 0);
      set_lu(1'b0);
      cyc_check("lumul_c1", 1, 1, 1, 0, 0, 0);
      is_mul_id = 0;
      cyc_check("lumul_c2", 1, 1, 0, 0, 0, 0);
      cyc_check("lumul_c3", 1, 1, 0, 0, 0, 0);
      cyc_check("lumul_c4", 1, 1, 0, 0, 0, 0);
      cyc_check("lumul_c5", 0, 0, 0, 1, 0, 0);

      // ---------------- DIV priority over MUL, 32 stalled cycles
      is_mul_id = 1; is_div_id = 1;
      #1;
      chk1("div.md_start", md_start, 1'b1);
      chk1("div.md_is_div_start", md_is_div, 1'b1);
      chk1("div.stall_start", stall_pc, 1'b1);
      @(negedge clk);
      clear_inputs();
      n_stall = 1;
      done_seen = 0; div_at_done = 0; stall_at_done = 1;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (md_done) begin
            done_seen = 1; div_at_done = md_is_div; stall_at_done = stall_pc;
            break;
         end
         if (stall_pc) n_stall++;
         @(negedge clk);
      end
      chk1("div.done_seen", done_seen, 1'b1);
      check("div.stall_count", n_stall, 32);
      chk1("div.md_is_div_done", div_at_done, 1'b1);
      chk1("div.stall_at_done", stall_at_done, 1'b0);
      exp_cnt = exp_cnt + 32'd32;
      @(negedge clk);
      cyc_check("div_idle", 0, 0, 0, 0, 0, 1);

      // ---------------- asynchronous reset in cycle 2 of BUSY
      is_mul_id = 1;
      cyc_check("rstb_c0", 1, 1, 1, 0, 0, 0);
      is_mul_id = 0;
      cyc_check("rstb_c1", 1, 1, 0, 0, 0, 0);
      set_lu(1'b1); branch_taken_id = 1;
      #1;
      chk1("rstb_c2.busy", md_busy, 1'b1);
      rst = 1'b0;
      #1;
      check_all_zero("rstb_in_reset");
      exp_cnt = '0;
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cyc_check($sformatf("rstb_after%0d", c), 0, 0, 0, 0, 0, 0);
      end

      // ---------------- stall counter saturation
      dut.stall_cnt_q = 32'hFFFF_FFFE;
      exp_cnt = 32'hFFFF_FFFE;
      set_lu(1'b1);
      cyc_check("sat_c0", 1, 0, 0, 0, 0, 0);
      cyc_check("sat_c1", 1, 0, 0, 0, 0, 0);
      cyc_check("sat_c2", 1, 0, 0, 0, 0, 0);
      set_lu(1'b0);
      cyc_check("sat_end", 0, 0, 0, 0, 0, 0);
      check("sat.final", stall_cycles, 32'hFFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning EX-side multiplier latency in cycles (legal range 2..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning EX-side divider latency in cycles (legal range 2..63).
REQ-003 SHALL have port clk  in  1  single pipeline clock, rising-edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rs_addr_id, rt_addr_id  in  5 each  source register numbers of the instruction in ID.
REQ-006 SHALL have ports uses_rs_id, uses_rt_id  in  1 each  ID instruction reads rs / rt.
REQ-007 SHALL have ports is_mul_id, is_div_id  in  1 each  ID instruction needs the multi-cycle multiplier / divider.
REQ-008 SHALL have port branch_taken_id  in  1  branch or jump redirect resolved in ID.
REQ-009 SHALL have ports is_lw_ex, write_ex  in  1 each; w_addr_ex  in  5  load flag, write-enable and destination of the instruction in EX.
REQ-010 SHALL have ports stall_pc, stall_if_id  out  1 each  hold the PC and the IF/ID register.
REQ-011 SHALL have port bubble_id_ex  out  1  force all ID/EX control fields to zero on the next edge.
REQ-012 SHALL have port flush_if_id  out  1  zero the IF/ID instruction on the next edge.
REQ-013 SHALL have ports md_start, md_is_div, md_busy, md_done  out  1 each  multiplier/divider sequencing.
REQ-014 SHALL have port stall_cycles  out  32  count of cycles with stall_pc high.

Function
REQ-015 SHALL compute load-use hazard LU = is_lw_ex & write_ex & (w_addr_ex != 0) & ((uses_rs_id & rs_addr_id == w_addr_ex) | (uses_rt_id & rt_addr_id == w_addr_ex)) combinationally.
REQ-016 SHALL, when LU=1, assert stall_pc, stall_if_id and bubble_id_ex in the same cycle; this normally lasts exactly one cycle.
REQ-017 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-018 SHALL, in IDLE with (is_mul_id | is_div_id) & !LU, pulse md_start for one cycle and latch md_is_div = is_div_id.
REQ-019 SHALL, on that same IDLE cycle, load down-counter cnt = (is_div_id ? DIV_CYCLES : MUL_CYCLES) - 1 and enter BUSY on the next edge.
REQ-020 SHALL give is_div_id priority when is_mul_id and is_div_id are both high.
REQ-021 SHALL, in the md_start cycle and throughout BUSY, assert stall_pc, stall_if_id, bubble_id_ex and md_busy.
REQ-022 SHALL, in BUSY, decrement cnt each cycle and move to DONE when cnt == 1.
REQ-023 SHALL give a total stall of exactly the configured latency; MUL_CYCLES=4 yields 4 stalled cycles.
REQ-024 SHALL, in DONE, pulse md_done, deassert all stall outputs so the instruction advances into EX, ignore is_mul_id/is_div_id, and return to IDLE.
REQ-025 SHALL accept back-to-back multi-cycle instructions with a minimum of one non-stalled DONE cycle between them.
REQ-026 SHALL set flush_if_id = branch_taken_id & !stall_pc; a stall suppresses the flush and the branch is re-evaluated on release.
REQ-027 SHALL increment stall_cycles every cycle stall_pc=1 and saturate at 32'hFFFFFFFF with no wrap.
REQ-028 SHALL keep md_is_div stable from md_start through md_done.
REQ-029 SHALL ignore LU during BUSY, because the EX instruction is then a bubble.
REQ-030 SHALL derive all outputs other than md_start, md_busy and md_done only from current inputs and current state, with no extra latency.

Reset
REQ-031 SHALL, while rst=0, asynchronously force state=IDLE, cnt=0, md_is_div=0 and stall_cycles=0.
REQ-032 SHALL drive all 1-bit outputs to 0 while rst=0.
REQ-033 SHALL, on reset mid-BUSY, abort the operation without emitting md_done; the first edge after release is evaluated from IDLE.

Structure
REQ-034 SHALL place FSM state encoding (2-bit localparams) and the default latency constants in shared package pipe_ctrl_pkg.
REQ-035 SHALL contain one sub-module, hazard_detect, holding the combinational LU logic; the FSM and counters reside in pipe_stall_ctrl.

Verification
REQ-036 SHALL verify load-use: is_lw_ex=1, write_ex=1, w_addr_ex=8, uses_rs_id=1, rs_addr_id=8 -> stall_pc=stall_if_id=bubble_id_ex=1 for 1 cycle; the same stimulus with w_addr_ex=0 -> no stall.
REQ-037 SHALL verify MUL: is_mul_id=1 held in IDLE with MUL_CYCLES=4 -> md_start at cycle 0, stalls in cycles 0-3, md_done and no stall at cycle 4, IDLE at cycle 5.
REQ-038 SHALL verify DIV priority: is_mul_id=is_div_id=1 -> md_is_div=1 and exactly 32 stalled cycles.
REQ-039 SHALL verify stall vs flush: branch_taken_id=1 during BUSY -> flush_if_id=0; in the DONE cycle -> flush_if_id=1.
REQ-040 SHALL verify reset: rst=0 at cycle 2 of BUSY -> all outputs 0 immediately, no md_done, stall_cycles=0.
REQ-041 SHALL verify saturation: stall_cycles preloaded to 32'hFFFFFFFE plus 3 stall cycles -> 32'hFFFFFFFF.
